// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and data access.
// One transaction is held on the port until ready or watchdog abort; results return with a one-cycle valid.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetchReq,
  input  logic [31:0] i_fetchAddr,
  output logic [31:0] o_fetchInst,
  output logic        o_fetchValid,
  input  logic        i_dataReq,
  input  logic        i_dataWrite,
  input  logic [1:0]  i_dataSize,
  input  logic [31:0] i_dataAddr,
  input  logic [31:0] i_dataWData,
  output logic [31:0] o_dataRData,
  output logic        o_dataValid,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [1:0]  o_memSize,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWData,
  input  logic [31:0] i_memRData,
  input  logic        i_memReady,
  output logic        o_stall,
  output logic        o_timeout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          last_data;

  logic fetch_req_m, data_req_m;
  logic grant_fetch, grant_data;
  logic busy, done, abort;

  // A requester is ignored during its own valid cycle while it retires or replaces the request.
  assign fetch_req_m = i_fetchReq & ~o_fetchValid;
  assign data_req_m  = i_dataReq & ~o_dataValid;

  assign grant_data  = (state == IDLE) & data_req_m & ~(last_data & fetch_req_m);
  assign grant_fetch = (state == IDLE) & fetch_req_m & ~grant_data;

  assign busy  = (state != IDLE);
  assign done  = busy & i_memReady;
  assign abort = busy & ~i_memReady & (wait_cnt == LAST_WAIT);

  assign o_stall = busy | fetch_req_m | data_req_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data)       state_next = DATA;
        else if (grant_fetch) state_next = FETCH;
      end
      FETCH, DATA: begin
        if (done || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_memReq     <= 1'b0;
      o_memWrite   <= 1'b0;
      o_memSize    <= 2'b00;
      o_memAddr    <= '0;
      o_memWData   <= '0;
      o_fetchInst  <= '0;
      o_fetchValid <= 1'b0;
      o_dataRData  <= '0;
      o_dataValid  <= 1'b0;
      o_timeout    <= 1'b0;
      wait_cnt     <= '0;
      last_data    <= 1'b0;
    end else begin
      o_fetchValid <= 1'b0;
      o_dataValid  <= 1'b0;
      if (grant_data) begin
        o_memReq   <= 1'b1;
        o_memWrite <= i_dataWrite;
        o_memSize  <= i_dataSize;
        o_memAddr  <= i_dataAddr;
        o_memWData <= i_dataWData;
        wait_cnt   <= '0;
      end else if (grant_fetch) begin
        o_memReq   <= 1'b1;
        o_memWrite <= 1'b0;
        o_memSize  <= 2'b10;
        o_memAddr  <= i_fetchAddr;
        o_memWData <= '0;
        wait_cnt   <= '0;
      end else if (done || abort) begin
        o_memReq   <= 1'b0;
        o_memWrite <= 1'b0;
        last_data  <= (state == DATA);
        if (abort) o_timeout <= 1'b1;
        if (state == FETCH) begin
          o_fetchValid <= 1'b1;
          o_fetchInst  <= done ? i_memRData : 32'd0;
        end else begin
          o_dataValid <= 1'b1;
          // A store leaves the previous load result in place.
          if (!o_memWrite) o_dataRData <= done ? i_memRData : 32'd0;
        end
      end else if (busy) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level scheduler predicts grant order and
// valid timing per cycle; a reactive memory model answers with per-transaction latency.
module tb_mem_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fetchReq, i_dataReq, i_dataWrite, i_memReady;
  logic [31:0] i_fetchAddr, i_dataAddr, i_dataWData, i_memRData;
  logic [1:0]  i_dataSize;
  logic [31:0] o_fetchInst, o_dataRData, o_memAddr, o_memWData;
  logic        o_fetchValid, o_dataValid, o_memReq, o_memWrite, o_stall, o_timeout;
  logic [1:0]  o_memSize;

  mem_port_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_fetchReq(i_fetchReq), .i_fetchAddr(i_fetchAddr),
    .o_fetchInst(o_fetchInst), .o_fetchValid(o_fetchValid),
    .i_dataReq(i_dataReq), .i_dataWrite(i_dataWrite), .i_dataSize(i_dataSize),
    .i_dataAddr(i_dataAddr), .i_dataWData(i_dataWData),
    .o_dataRData(o_dataRData), .o_dataValid(o_dataValid),
    .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memSize(o_memSize),
    .o_memAddr(o_memAddr), .o_memWData(o_memWData),
    .i_memRData(i_memRData), .i_memReady(i_memReady),
    .o_stall(o_stall), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;   // wait cycles before the memory answers
    int          g;     // cycle at whose end the grant happens
    int          v;     // valid cycle
    bit          to;    // watchdog expires first
  } txn_t;

  txn_t fq[$], dq[$], tx[$];

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_last_data = 1'b0;
  bit          m_to        = 1'b0;
  logic [31:0] m_finst     = '0;
  logic [31:0] m_drdata    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic txn_t mk(bit d, bit wr, logic [1:0] sz, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int lat);
    txn_t t;
    t.is_data = d;
    t.wr      = d & wr;
    t.size    = d ? sz : 2'b10;
    t.addr    = addr;
    t.wdata   = d ? wdata : 32'd0;
    t.rdata   = rdata;
    t.lat     = lat;
    t.g       = 0;
    t.v       = 0;
    t.to      = 1'b0;
    return t;
  endfunction

  // Service order: data first unless the last served was data and fetch waits;
  // a requester in its own valid cycle cannot win that cycle's arbitration.
  task automatic schedule();
    int  fi = 0, di = 0, free = 0, fv = -1, dv = -1, dur;
    bit  last = m_last_data;
    bit  fc, dc, pick;
    txn_t t;
    while (fi < fq.size() || di < dq.size()) begin
      fc = (fi < fq.size()) && (free != fv);
      dc = (di < dq.size()) && (free != dv);
      if (!fc && !dc) begin
        free++;
        continue;
      end
      pick = dc && !(fc && last);
      if (pick) begin t = dq[di]; di++; end
      else      begin t = fq[fi]; fi++; end
      t.to = (t.lat >= MW);
      dur  = t.to ? MW : t.lat + 1;
      t.g  = free;
      t.v  = free + dur + 1;
      tx.push_back(t);
      free = t.v;
      if (pick) dv = t.v;
      else      fv = t.v;
      last = pick;
    end
    m_last_data = last;
  endtask

  // Called at a negedge; cycle 0 presents the first requests at that same negedge.
  task automatic run_scn();
    int fi = 0, di = 0, vlast, mcnt = 0;
    schedule();
    vlast = tx[tx.size()-1].v;
    for (int c = 0; c <= vlast + 1; c++) begin
      int act;
      bit efv, edv;
      int lat;
      logic [31:0] rd;
      if (c > 0) @(negedge clk);
      act = -1; efv = 0; edv = 0;
      foreach (tx[k]) begin
        if (tx[k].g < c && c < tx[k].v) act = k;
        if (tx[k].v == c) begin
          if (tx[k].is_data) begin
            edv = 1;
            if (!tx[k].wr) m_drdata = tx[k].to ? 32'd0 : tx[k].rdata;
          end else begin
            efv = 1;
            m_finst = tx[k].to ? 32'd0 : tx[k].rdata;
          end
          if (tx[k].to) m_to = 1'b1;
        end
      end
      check("memReq", 32'(o_memReq), 32'(act >= 0));
      if (act >= 0 && o_memReq) begin
        check("memAddr",  o_memAddr,         tx[act].addr);
        check("memWrite", 32'(o_memWrite),   32'(tx[act].wr));
        check("memSize",  32'(o_memSize),    32'(tx[act].size));
        check("memWData", o_memWData,        tx[act].wdata);
      end
      check("fetchValid", 32'(o_fetchValid), 32'(efv));
      check("dataValid",  32'(o_dataValid),  32'(edv));
      check("fetchInst",  o_fetchInst,       m_finst);
      check("dataRData",  o_dataRData,       m_drdata);
      check("timeout",    32'(o_timeout),    32'(m_to));
      if (c > 0)
        check("stall", 32'(o_stall),
              32'((act >= 0) || (fi < fq.size() && !efv) || (di < dq.size() && !edv)));

      // memory: answers after lat wait cycles; ready is random noise while idle
      if (o_memReq) begin
        lat = 1000; rd = 32'hBAD0_0000;
        foreach (tx[k]) if (tx[k].addr == o_memAddr) begin lat = tx[k].lat; rd = tx[k].rdata; end
        i_memReady = (mcnt == lat);
        i_memRData = i_memReady ? rd : $urandom;
        mcnt++;
      end else begin
        mcnt = 0;
        i_memReady = 1'($urandom_range(0, 1));
        i_memRData = $urandom;
      end

      if (efv) fi++;
      if (edv) di++;
      if (fi < fq.size()) begin
        i_fetchReq  = 1'b1;
        i_fetchAddr = fq[fi].addr;
      end else begin
        i_fetchReq  = 1'b0;
        i_fetchAddr = $urandom;
      end
      if (di < dq.size()) begin
        i_dataReq   = 1'b1;
        i_dataWrite = dq[di].wr;
        i_dataSize  = dq[di].size;
        i_dataAddr  = dq[di].addr;
        i_dataWData = dq[di].wdata;
      end else begin
        i_dataReq   = 1'b0;
        i_dataWrite = 1'($urandom_range(0, 1));
        i_dataSize  = 2'($urandom_range(0, 3));
        i_dataAddr  = $urandom;
        i_dataWData = $urandom;
      end
    end
    tx.delete(); fq.delete(); dq.delete();
  endtask

  function automatic int rand_lat();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(MW, MW + 2));
    return int'($urandom_range(0, 3));
  endfunction

  task automatic gen_scn();
    int nf, nd;
    logic [31:0] a;
    nf = int'($urandom_range(0, 2));
    nd = int'($urandom_range(0, 2));
    if (nf == 0 && nd == 0) nd = 1;
    for (int i = 0; i < nf; i++) begin
      a = $urandom; a[31] = 1'b0; a[2:0] = 3'(i);
      fq.push_back(mk(0, 0, 2'b10, a, 0, $urandom, rand_lat()));
    end
    for (int i = 0; i < nd; i++) begin
      a = $urandom; a[31] = 1'b1; a[2:0] = 3'(i);
      dq.push_back(mk(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), a,
                      $urandom, $urandom, rand_lat()));
    end
  endtask

  task automatic reset_model();
    m_last_data = 1'b0; m_to = 1'b0; m_finst = '0; m_drdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_fetchReq = 0; i_fetchAddr = 0; i_dataReq = 0; i_dataWrite = 0; i_dataSize = 0;
    i_dataAddr = 0; i_dataWData = 0; i_memRData = 0; i_memReady = 0;
    #1;
    check("rst memReq",     32'(o_memReq),     0);
    check("rst fetchValid", 32'(o_fetchValid), 0);
    check("rst dataValid",  32'(o_dataValid),  0);
    check("rst timeout",    32'(o_timeout),    0);
    check("rst stall",      32'(o_stall),      0);
    check("rst memAddr",    o_memAddr,         0);
    check("rst fetchInst",  o_fetchInst,       0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // fetch with three wait cycles
    fq.push_back(mk(0, 0, 2'b10, 32'h0000_0010, 0, 32'h0000_0013, 3));
    run_scn();
    // fetch and byte load together, zero-wait
    fq.push_back(mk(0, 0, 2'b10, 32'h0000_0020, 0, 32'h1111_2222, 0));
    dq.push_back(mk(1, 0, 2'b00, 32'h0000_0100, 0, 32'h0000_00A5, 0));
    run_scn();
    // back-to-back data with fetch continuously pending
    dq.push_back(mk(1, 0, 2'b10, 32'h0000_0300, 0, 32'hCAFE_0001, 0));
    dq.push_back(mk(1, 0, 2'b01, 32'h0000_0304, 0, 32'hCAFE_0002, 1));
    fq.push_back(mk(0, 0, 2'b10, 32'h0000_0040, 0, 32'h5555_0001, 0));
    fq.push_back(mk(0, 0, 2'b10, 32'h0000_0044, 0, 32'h5555_0002, 2));
    run_scn();
    // store keeps the last load result
    dq.push_back(mk(1, 1, 2'b10, 32'h0000_0200, 32'hDEAD_BEEF, 32'h7777_7777, 1));
    run_scn();
    // hung memory on a load, then a good fetch with the flag still set
    dq.push_back(mk(1, 0, 2'b10, 32'h0000_0500, 0, 32'h9999_9999, MW + 2));
    run_scn();
    fq.push_back(mk(0, 0, 2'b10, 32'h0000_0060, 0, 32'h1234_5678, 0));
    run_scn();

    // reset in the middle of a data transaction
    i_memReady = 1'b0;
    i_dataReq = 1'b1; i_dataWrite = 1'b0; i_dataSize = 2'b10;
    i_dataAddr = 32'h0000_0400; i_dataWData = 32'h0;
    repeat (3) @(negedge clk);
    check("pre-rst memReq", 32'(o_memReq), 1);
    #2 rst = 1'b1;
    #1;
    check("mid-rst memReq",    32'(o_memReq),    0);
    check("mid-rst dataValid", 32'(o_dataValid), 0);
    check("mid-rst timeout",   32'(o_timeout),   0);
    check("mid-rst dataRData", o_dataRData,      0);
    @(negedge clk);
    check("in-rst dataValid", 32'(o_dataValid), 0);
    rst = 1'b0;
    reset_model();
    dq.push_back(mk(1, 0, 2'b10, 32'h0000_0400, 0, 32'h0BAD_F00D, 1));
    run_scn();

    for (int s = 0; s < 60; s++) begin
      gen_scn();
      run_scn();
    end

    #2 rst = 1'b1;
    #1;
    check("end-rst timeout",   32'(o_timeout), 0);
    check("end-rst fetchInst", o_fetchInst,    0);
    check("end-rst dataRData", o_dataRData,    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch and data (load/store) access for the multi-cycle core.
- Data requests come from the controller's memReq/memWrite/memSize decode. Fetch requests come from the PC stage.
- Latches one transaction at a time and holds it stable on the memory port until the memory's ready response. Returns read data with a one-cycle valid pulse.
- Stalls the core while a request is outstanding and flags hung memory with a watchdog.

Parameters:
- MAX_WAIT, 255: wait cycles allowed in a transaction before abort. Range 1..65535; counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_fetchReq  in  1  fetch request, level
- i_fetchAddr  in  32  fetch address
- o_fetchInst  out  32  fetched instruction, registered
- o_fetchValid  out  1  one-cycle pulse, o_fetchInst valid
- i_dataReq  in  1  data request, level (controller memReq)
- i_dataWrite  in  1  1=store, 0=load
- i_dataSize  in  2  00 byte, 01 half, 10 word
- i_dataAddr  in  32  data address
- i_dataWData  in  32  store data
- o_dataRData  out  32  load data, registered
- o_dataValid  out  1  one-cycle pulse, data transaction complete
- o_memReq  out  1  memory request, registered
- o_memWrite  out  1  memory write enable, registered
- o_memSize  out  2  memory access size, registered
- o_memAddr  out  32  memory address, registered
- o_memWData  out  32  memory write data, registered
- i_memRData  in  32  memory read data
- i_memReady  in  1  memory completion, sampled only in FETCH/DATA
- o_stall  out  1  core stall, combinational
- o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: the asynchronous, active-high rst forces state IDLE and clears every output, all data registers and the wait counter to 0.
  - Applies mid-transaction too: o_memReq drops immediately and no valid pulse is produced.
- States: IDLE, FETCH, DATA.
- IDLE arbitration, evaluated at each edge:
  - Data has priority over fetch, except when the last completed grant was DATA and the fetch request is pending. Then fetch wins, so fetch cannot starve.
  - A requester whose valid is high in the current cycle is masked from arbitration for that cycle. Requesters drop or replace their request within that cycle.
- Grant actions (IDLE -> FETCH or IDLE -> DATA):
  - Register o_memReq=1 and the address fields.
  - FETCH: o_memWrite=0, o_memSize=10, o_memWData=0.
  - DATA: o_memWrite, o_memSize and o_memWData come from the i_data* inputs.
  - Memory outputs stay frozen until completion; input changes are ignored while in FETCH/DATA.
- Completion: at the edge where i_memReady=1 in FETCH/DATA:
  - State returns to IDLE and o_memReq and o_memWrite clear.
  - FETCH: o_fetchInst <= i_memRData, o_fetchValid=1 for the next cycle.
  - DATA: o_dataValid=1 for the next cycle. For a load, o_dataRData <= i_memRData; for a store, o_dataRData keeps its previous value.
- Latency: the grant edge, then at least one edge to see ready, so a zero-wait memory takes 2 cycles from request to valid. Each completion is followed by one IDLE cycle (the valid cycle) before the next grant.
- Watchdog:
  - The counter clears on grant and increments each FETCH/DATA cycle without ready.
  - When it reaches MAX_WAIT, the transaction aborts: state goes to IDLE, o_memReq clears, the matching valid pulses with data 0 (load/fetch), and o_timeout sets.
  - o_timeout stays set until rst.
  - i_memReady on the abort edge takes precedence: normal completion, no timeout.
- o_stall = (state != IDLE) | (any unmasked request high in IDLE). It is low in the valid cycle unless the other requester is pending.
- Valid pulses last exactly one cycle. o_fetchInst and o_dataRData hold their values until overwritten.
- Addresses and sizes pass through unmodified; alignment is not checked here.

Test Plan:
- Reset, then fetch req at addr 0x0000_0010 with a memory ready after 3 wait cycles, rdata 0x0000_0013 -> o_memReq high 4 cycles with addr 0x10 and size 10; o_fetchValid pulses once; o_fetchInst=0x0000_0013; o_stall low in the valid cycle.
- Fetch and data load (0x100, size 00) raised together, ready immediate -> DATA granted first, then FETCH granted the cycle after dataValid. Both valids pulse once each, in that order.
- Back-to-back data requests with fetch continuously pending -> after each data completion fetch is served next, with alternating grants D,F,D,F.
- Store to 0x200, wdata 0xDEADBEEF, size 10, ready after 1 cycle -> o_memWrite=1 with data held stable throughout; dataValid pulses; o_dataRData unchanged from the prior load.
- MAX_WAIT=4, ready held low -> abort after 4 wait cycles; dataValid pulses with o_dataRData=0; o_timeout=1 and stays set through later good transactions until rst.
- rst asserted mid-DATA between clock edges -> o_memReq, state and valids clear immediately. No valid pulse after rst release, and a pending request is re-granted normally.
